// File: rtl/autosym_restriction_eval.sv
// autosym_restriction_eval: maps a full N_IN-bit input vector through a
// loadable XOR transform onto K reduced variables, then evaluates a loadable
// sum-of-products cube list on the reduced vector, one cube per cycle.
module autosym_restriction_eval #(
    parameter int unsigned N_IN      = 15,
    parameter int unsigned K         = 8,
    parameter int unsigned MAX_CUBES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_sel,
    input  logic [4:0]      cfg_addr,
    input  logic [15:0]     cfg_data,
    output logic            busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_y
);

    localparam int unsigned IDX_W  = $clog2(MAX_CUBES);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned ROW_AW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFORM = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;

    // Programmable tables
    logic [N_IN-1:0]   rows_q [K];
    logic [K-1:0]      care_q [MAX_CUBES];
    logic [K-1:0]      val_q  [MAX_CUBES];
    logic [CNT_W-1:0]  count_q;

    // Datapath registers
    logic [N_IN-1:0]   x_q;
    logic [K-1:0]      z_q;
    logic [IDX_W-1:0]  idx_q;

    logic [K-1:0]      z_next_c;
    logic              cube_hit_c;
    logic              cube_last_c;
    logic [5:0]        cnt_raw_c;
    logic [CNT_W-1:0]  cnt_clamped_c;

    // Reduced vector: each z bit is the parity of x masked by its transform row
    always_comb begin
        z_next_c = '0;
        for (int i = 0; i < K; i++) begin
            z_next_c[i] = ^(x_q & rows_q[i]);
        end
    end

    // Cube match on the current index and end-of-list detection
    always_comb begin
        cube_hit_c  = (((z_q ^ val_q[idx_q]) & care_q[idx_q]) == '0);
        cube_last_c = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));
    end

    // Cube count write payload, saturated at the table depth
    always_comb begin
        cnt_raw_c = cfg_data[5:0];
        if (32'(cnt_raw_c) > MAX_CUBES) begin
            cnt_clamped_c = CNT_W'(MAX_CUBES);
        end else begin
            cnt_clamped_c = CNT_W'(cnt_raw_c);
        end
    end

    // Configuration tables; writes land only while idle, dropped otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                rows_q[i] <= '0;
            end
            for (int j = 0; j < MAX_CUBES; j++) begin
                care_q[j] <= '0;
                val_q[j]  <= '0;
            end
            count_q <= '0;
        end else if (cfg_we && (state_q == IDLE)) begin
            case (cfg_sel)
                2'd0: begin
                    if (32'(cfg_addr) < K) begin
                        rows_q[cfg_addr[ROW_AW-1:0]] <= cfg_data[N_IN-1:0];
                    end
                end
                2'd1: begin
                    care_q[cfg_addr[IDX_W-1:0]] <= cfg_data[K-1:0];
                    val_q[cfg_addr[IDX_W-1:0]]  <= cfg_data[2*K-1:K];
                end
                2'd2: begin
                    count_q <= cnt_clamped_c;
                end
                default: begin
                end
            endcase
        end
    end

    // Evaluation FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_y     <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            x_q       <= '0;
            z_q       <= '0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= in_x;
                        state_q  <= XFORM;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                XFORM: begin
                    z_q   <= z_next_c;
                    idx_q <= '0;
                    if (count_q == '0) begin
                        out_y     <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    if (cube_hit_c) begin
                        out_y     <= 1'b1;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else if (cube_last_c) begin
                        out_y     <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/autosym_restriction_eval.md
Name: autosym_restriction_eval

Overview:
- Sequential evaluator that reconstructs an autosymmetric Boolean function from its restriction.
- Each accepted 15-bit input vector x goes through a loadable linear (XOR) transformation to a K-bit reduced vector z.
- z is then checked against a loadable sum-of-products cube list, one cube per cycle, and the single-bit result y is returned over a valid/ready handshake.
- The block is the companion to the optimised restriction netlists: it is the programmable end that maps the full input space onto the restriction, so benches can cross-check restriction netlists against full-function PLAs.

Parameters:
- N_IN, 15, number of primary inputs x.
- K, 8, number of reduced variables z (transformation rows).
- MAX_CUBES, 32, cube-table depth; power of two.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- cfg_we  input  1  configuration write strobe.
- cfg_sel  input  2  target: 0 = transform row, 1 = cube, 2 = cube count, 3 = reserved.
- cfg_addr  input  5  row index (0..K-1) or cube index (0..MAX_CUBES-1).
- cfg_data  input  16  payload, defined per target under Behaviour.
- busy  output  1  high whenever FSM is not IDLE.
- in_valid  input  1  input vector valid.
- in_ready  output  1  high only in IDLE.
- in_x  input  N_IN  input vector x.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed.
- out_y  output  1  function value.

Behaviour:
- Reset, synchronous: FSM = IDLE; out_valid = 0; out_y = 0; busy = 0; in_ready = 1 from the first cycle after reset; all transform rows, cube entries and cube count cleared to 0.
- Reset wins over every other event. Reset mid-operation discards the pending result with no output.
- Config payloads:
  - cfg_sel = 0: row[cfg_addr] = cfg_data[N_IN-1:0]. Addresses >= K are ignored.
  - cfg_sel = 1: care[cfg_addr] = cfg_data[K-1:0], val[cfg_addr] = cfg_data[2K-1:K].
  - cfg_sel = 2: count = min(cfg_data[5:0], MAX_CUBES).
  - cfg_sel = 3: ignored.
- Config writes take effect only in IDLE. Writes while busy are dropped silently.
- A write and an input acceptance in the same IDLE cycle: the write completes, and the accepted vector is evaluated with the new tables.
- FSM:
  - IDLE: on in_valid & in_ready, latch in_x and go to XFORM.
  - XFORM (1 cycle): z[i] = XOR-reduce(x & row[i]) for i = 0..K-1, registered. Next state is EVAL with idx = 0, or DONE with y = 0 if count == 0.
  - EVAL (1 cycle per cube): cube idx hits iff ((z ^ val[idx]) & care[idx]) == 0.
    - Hit: y = 1, go to DONE (early exit).
    - Miss with idx == count-1: y = 0, go to DONE.
    - Otherwise idx++.
  - DONE: out_valid = 1 and out_y stable. On out_ready, go to IDLE with out_valid = 0.
- care == 0 is a tautology cube and always hits. Cube entries at index >= count are never read.
- Latency, with the acceptance edge counted as edge 0:
  - hit on cube h: out_valid visible after edge 2+h;
  - all-miss: out_valid visible after edge 1+count;
  - count == 0: out_valid visible after edge 1.
- Throughput is one vector per evaluation. There is no overlap: in_ready is low from XFORM through the DONE handshake.
- out_valid and out_y change only on a handshake or reset. out_ready while out_valid == 0 has no effect.
- The earliest next acceptance is the cycle after the DONE handshake, so there is no same-cycle out-to-in bypass.

Test Plan:
- Reset, then idle: in_ready = 1, out_valid = 0, busy = 0. Send x = 0x7FFF with count = 0 -> out_y = 0 after edge 1.
- Identity-row check:
  - Setup: row[i] = 1<<i for all i; cube0 care = 0x01, val = 0x01; count = 1.
  - x = 0x0001 -> y = 1 after edge 2.
  - x = 0x0002 -> y = 0 after edge 2.
- XOR transform:
  - Setup: row[0] = 0x6000 (x13 ^ x14); cube0 care = 0x01, val = 0x01; count = 1.
  - x = 0x2000 -> y = 1.
  - x = 0x6000 -> y = 0.
- Early exit: count = 4, only cube 3 matches z -> out_valid after edge 5. Then make cube 0 also match -> out_valid after edge 2.
- Backpressure and config-while-busy:
  - Hold out_ready = 0 for 10 cycles -> out_valid and out_y stable, in_ready = 0.
  - A cfg write to row 0 during this window is dropped: a readback evaluation matches the old row.
- Reset during EVAL at idx = 2 -> next cycle IDLE, out_valid = 0, count = 0, and all tables read back as zero.
